// File: rtl/pll_measure_sequencer_if.sv
// -----------------------------------------------------------------------------
// pll_measure_sequencer_if
//   Avalon-MM bus between the measurement sequencer (master) and the PLL
//   frequency-counter slave. No waitrequest; reads return registered data
//   the cycle after m_read.
//
//   m_address   [3:0]   slave register index
//   m_write             single-cycle write strobe
//   m_read              single-cycle read strobe
//   m_writedata [31:0]  write data
//   m_readdata  [31:0]  slave read data (valid the cycle after m_read)
// -----------------------------------------------------------------------------
interface pll_measure_sequencer_if;
  logic [3:0]  m_address;
  logic        m_write;
  logic        m_read;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;

  modport master (
    output m_address,
    output m_write,
    output m_read,
    output m_writedata,
    input  m_readdata
  );

  modport slave (
    input  m_address,
    input  m_write,
    input  m_read,
    input  m_writedata,
    output m_readdata
  );
endinterface

// File: rtl/pll_measure_sequencer.sv
// -----------------------------------------------------------------------------
// pll_measure_sequencer
//   Drives the PLL frequency-counter slave through clear / program window /
//   go / poll / settle / read count, for a latched number of measurements,
//   and accumulates the counts.
//
//   Optional feature macro: PLL_SEQ_LOCK_CHECK_EN
//     defined     -> slave register 5 (locked) is read first; unlocked aborts
//                    the sequence with error.
//     undefined   -> lock status is never read.
//
// Ports
//   avalon_clock       sole clock
//   resetn             asynchronous active-low reset
//   start              one-cycle request, honoured only when idle
//   window  [31:0]     reference cycles per measurement (0 -> 1)
//   repeats [7:0]      number of measurements (0 -> 1)
//   busy               high while a sequence runs (low in the done cycle)
//   done               one-cycle end-of-sequence pulse
//   error              sticky lock-failure / poll-timeout flag
//   result  [31:0]     last PLL count read
//   result_valid       one-cycle pulse when result updates
//   sum     [39:0]     running sum of results for the current sequence
//   m                  Avalon-MM master port
//
// Parameters
//   SETTLE       cycles between go falling and the count read (min 1)
//   POLL_LIMIT   completion polls (seen busy) before timeout
// -----------------------------------------------------------------------------
module pll_measure_sequencer #(
  parameter int unsigned SETTLE     = 4,
  parameter logic [31:0] POLL_LIMIT = 32'hFFFF_FFFF
) (
  input  logic        avalon_clock,
  input  logic        resetn,
  input  logic        start,
  input  logic [31:0] window,
  input  logic [7:0]  repeats,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] result,
  output logic        result_valid,
  output logic [39:0] sum,
  pll_measure_sequencer_if.master m
);

  localparam logic [3:0] ADDR_GO  = 4'd0;
  localparam logic [3:0] ADDR_NUM = 4'd1;
  localparam logic [3:0] ADDR_CLR = 4'd2;
  localparam logic [3:0] ADDR_CNT = 4'd4;
`ifdef PLL_SEQ_LOCK_CHECK_EN
  localparam logic [3:0] ADDR_LOCK = 4'd5;
`endif

  // A zero settle time still spends one cycle in the settle state.
  localparam int unsigned SETTLE_CYC = (SETTLE == 0) ? 1 : SETTLE;
  localparam int          SW         = $clog2(SETTLE_CYC + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOCK_RD, S_LOCK_W, S_CLEAR, S_SET_N, S_GO, S_POLL_RD,
    S_POLL_W, S_SETTLE, S_CNT_RD, S_CNT_W, S_NEXT, S_DONE
  } state_t;

  state_t        state_q,  state_d;
  logic [31:0]   window_q, window_d;
  logic [7:0]    remain_q, remain_d;
  logic [31:0]   poll_q,   poll_d;
  logic [SW-1:0] settle_q, settle_d;
  logic          error_q,  error_d;
  logic [31:0]   result_q, result_d;
  logic [39:0]   sum_q,    sum_d;

  always_ff @(posedge avalon_clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      window_q <= '0;
      remain_q <= '0;
      poll_q   <= '0;
      settle_q <= '0;
      error_q  <= 1'b0;
      result_q <= '0;
      sum_q    <= '0;
    end else begin
      state_q  <= state_d;
      window_q <= window_d;
      remain_q <= remain_d;
      poll_q   <= poll_d;
      settle_q <= settle_d;
      error_q  <= error_d;
      result_q <= result_d;
      sum_q    <= sum_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    window_d = window_q;
    remain_d = remain_q;
    poll_d   = poll_q;
    settle_d = settle_q;
    error_d  = error_q;
    result_d = result_q;
    sum_d    = sum_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          window_d = (window == '0)  ? 32'd1 : window;
          remain_d = (repeats == '0) ? 8'd1  : repeats;
          sum_d    = '0;
          error_d  = 1'b0;
`ifdef PLL_SEQ_LOCK_CHECK_EN
          state_d  = S_LOCK_RD;
`else
          state_d  = S_CLEAR;
`endif
        end
      end
`ifdef PLL_SEQ_LOCK_CHECK_EN
      S_LOCK_RD: state_d = S_LOCK_W;
      S_LOCK_W: begin
        if (m.m_readdata[0]) begin
          state_d = S_CLEAR;
        end else begin
          error_d = 1'b1;
          state_d = S_DONE;
        end
      end
`endif
      S_CLEAR: state_d = S_SET_N;
      S_SET_N: state_d = S_GO;
      S_GO: begin
        poll_d  = '0;
        state_d = S_POLL_RD;
      end
      S_POLL_RD: state_d = S_POLL_W;
      S_POLL_W: begin
        if (m.m_readdata[0]) begin
          // go still set: count this poll and give up at the limit
          poll_d = poll_q + 32'd1;
          if (poll_d == POLL_LIMIT) begin
            error_d = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_POLL_RD;
          end
        end else begin
          settle_d = '0;
          state_d  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = S_CNT_RD;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      S_CNT_RD: state_d = S_CNT_W;
      S_CNT_W: begin
        result_d = m.m_readdata;
        sum_d    = sum_q + {8'd0, m.m_readdata};
        state_d  = S_NEXT;
      end
      S_NEXT: begin
        remain_d = remain_q - 8'd1;
        state_d  = (remain_d != '0) ? S_CLEAR : S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus strobes decode straight from the state register so that an
  // asynchronous reset drops them immediately.
  always_comb begin
    m.m_read      = 1'b0;
    m.m_write     = 1'b0;
    m.m_address   = '0;
    m.m_writedata = '0;
    case (state_q)
`ifdef PLL_SEQ_LOCK_CHECK_EN
      S_LOCK_RD: begin
        m.m_read    = 1'b1;
        m.m_address = ADDR_LOCK;
      end
`endif
      S_CLEAR: begin
        m.m_write   = 1'b1;
        m.m_address = ADDR_CLR;
      end
      S_SET_N: begin
        m.m_write     = 1'b1;
        m.m_address   = ADDR_NUM;
        m.m_writedata = window_q;
      end
      S_GO: begin
        m.m_write     = 1'b1;
        m.m_address   = ADDR_GO;
        m.m_writedata = 32'd1;
      end
      S_POLL_RD: begin
        m.m_read    = 1'b1;
        m.m_address = ADDR_GO;
      end
      S_CNT_RD: begin
        m.m_read    = 1'b1;
        m.m_address = ADDR_CNT;
      end
      default: ;
    endcase
  end

  assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done         = (state_q == S_DONE);
  assign result_valid = (state_q == S_NEXT);
  assign error        = error_q;
  assign result       = result_q;
  assign sum          = sum_q;

endmodule

// File: tb/tb_pll_measure_sequencer.sv
`timescale 1ns/1ps
module tb_pll_measure_sequencer;
  localparam int SETTLE_P = 4;
  localparam int POLL_LIM = 64;
`ifdef PLL_SEQ_LOCK_CHECK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] window = '0;
  logic [7:0]  repeats = '0;
  logic        busy, done, error, result_valid;
  logic [31:0] result;
  logic [39:0] sum;

  pll_measure_sequencer_if bus();

  pll_measure_sequencer #(.SETTLE(SETTLE_P), .POLL_LIMIT(32'(POLL_LIM))) dut (
    .avalon_clock(clk), .resetn(resetn), .start(start), .window(window),
    .repeats(repeats), .busy(busy), .done(done), .error(error),
    .result(result), .result_valid(result_valid), .sum(sum), .m(bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // ---------------- slave model: pll_clock = 2x avalon_clock ----------------
  logic        s_go = 1'b0, s_locked = 1'b1, s_hang = 1'b0;
  logic [31:0] s_num = '0, s_pll = '0;
  int          s_cnt = 0;
  logic [1:0]  jit = '0;
  logic [31:0] exp_q[$];      // counts produced by the slave, in order
  int          cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
    jit <= 2'($urandom_range(2));
    if (bus.m_read) begin
      case (bus.m_address)
        4'd0:    bus.m_readdata <= {31'd0, s_go};
        4'd1:    bus.m_readdata <= s_num;
        4'd4:    bus.m_readdata <= s_pll;
        4'd5:    bus.m_readdata <= {31'd0, s_locked};
        default: bus.m_readdata <= '0;
      endcase
    end
    if (s_go && !s_hang) begin
      if (s_cnt <= 1) begin
        s_go  <= 1'b0;
        s_pll <= 32'(2 * s_num + jit - 1);
        exp_q.push_back(32'(2 * s_num + jit - 1));
      end else begin
        s_cnt <= s_cnt - 1;
      end
    end
    if (bus.m_write) begin
      case (bus.m_address)
        4'd0: begin s_go <= bus.m_writedata[0]; s_cnt <= int'(s_num); end
        4'd1: s_num <= bus.m_writedata;
        4'd2: begin s_go <= 1'b0; s_pll <= '0; end
        default: ;
      endcase
    end
  end

  // ---------------- monitor / per-cycle compare ----------------
  logic [35:0] wlog[$];
  int          rd_cnt[16];
  int          rv_cnt = 0, done_cnt = 0, done_cyc = 0, last_rd0 = -100, exp_rv = 0, cur_w = 1;
  bit          last_rv = 1'b0;
  longint      exp_sum = 0;

  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (resetn) begin
        chk(!(bus.m_read && bus.m_write), "one_strobe", 1, 0);
        if (bus.m_write) wlog.push_back({bus.m_address, bus.m_writedata});
        if (bus.m_read) begin
          rd_cnt[bus.m_address]++;
          if (bus.m_address == 4'd0) last_rd0 = cyc;
          if (bus.m_address == 4'd4)
            chk(cyc - last_rd0 == 2 + SETTLE_P, "settle_gap", cyc - last_rd0, 2 + SETTLE_P);
        end
        if (result_valid) begin
          if (exp_q.size() == 0) begin
            chk(1'b0, "result_unexpected", result, 0);
          end else begin
            e = exp_q.pop_front();
            chk(result == e, "result", result, e);
            exp_sum += e;
          end
          chk(result + 2 >= 32'(2 * cur_w) && result <= 32'(2 * cur_w + 2), "result_range", result, 2 * cur_w);
          rv_cnt++;
        end
        if (busy || done) chk(sum == exp_sum, "sum", sum, exp_sum);
        if (done) begin
          chk(!busy, "busy_at_done", busy, 0);
          chk(!result_valid, "rv_with_done", result_valid, 0);
          if (exp_rv > 0) chk(last_rv, "rv_before_done", last_rv, 1);
          done_cnt++;
          done_cyc = cyc;
        end
        last_rv = result_valid;
      end
    end
  end

  task automatic clear_model(input int weff, input int erv);
    wlog.delete();
    exp_q.delete();
    for (int i = 0; i < 16; i++) rd_cnt[i] = 0;
    rv_cnt = 0; done_cnt = 0; exp_sum = 0; cur_w = weff; exp_rv = erv;
    s_go = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({busy, done, error, result_valid, bus.m_read, bus.m_write} == 6'd0, {tag, "_flags"},
        {busy, done, error, result_valid, bus.m_read, bus.m_write}, 0);
    chk(result == 0, {tag, "_result"}, result, 0);
    chk(sum == 0, {tag, "_sum"}, sum, 0);
    chk(bus.m_address == 0 && bus.m_writedata == 0, {tag, "_bus"}, {bus.m_address, bus.m_writedata}, 0);
  endtask

  task automatic run_seq(input logic [31:0] w, input logic [7:0] r, input bit locked,
                         input bit hang, input bit poke);
    int weff, reps, erv, t0;
    bit lock_fail, got;
    logic [35:0] exp_w[$];
    weff = (w == 0) ? 1 : int'(w);
    reps = (r == 0) ? 1 : int'(r);
    lock_fail = LOCK_EN && !locked;
    erv = (lock_fail || hang) ? 0 : reps;
    s_locked = locked;
    s_hang = hang;
    clear_model(weff, erv);
    start = 1'b1; window = w; repeats = r; t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0; window = $urandom; repeats = 8'($urandom);
    chk(busy == 1'b1, "busy_after_start", busy, 1);
    chk(error == 1'b0, "error_cleared", error, 0);
    got = 1'b0;
    for (int i = 0; i < 20000 && !got; i++) begin
      @(posedge clk); #1;
      start = (poke && i == 5) ? 1'b1 : 1'b0;
      if (done_cnt > 0) got = 1'b1;
    end
    start = 1'b0;
    chk(got, "done_timeout", got, 1);
    repeat (4) @(posedge clk);
    #1;
    chk(done_cnt == 1, "done_count", done_cnt, 1);
    chk(error == (lock_fail || hang), "error", error, lock_fail || hang);
    chk(rv_cnt == erv, "rv_count", rv_cnt, erv);
    chk(rd_cnt[5] == (LOCK_EN ? 1 : 0), "lock_reads", rd_cnt[5], LOCK_EN ? 1 : 0);
    chk(rd_cnt[4] == erv, "cnt_reads", rd_cnt[4], erv);
    if (hang) chk(rd_cnt[0] == POLL_LIM, "poll_reads", rd_cnt[0], POLL_LIM);
    if (lock_fail) chk(done_cyc - t0 <= 4, "lockfail_latency", done_cyc - t0, 4);
    if (!lock_fail) begin
      for (int k = 0; k < (hang ? 1 : reps); k++) begin
        exp_w.push_back({4'd2, 32'd0});
        exp_w.push_back({4'd1, 32'(weff)});
        exp_w.push_back({4'd0, 32'd1});
      end
    end
    chk(wlog.size() == exp_w.size(), "write_count", wlog.size(), exp_w.size());
    for (int k = 0; k < exp_w.size() && k < wlog.size(); k++)
      chk(wlog[k] == exp_w[k], "write_trace", wlog[k], exp_w[k]);
    $display("seq w=%0d r=%0d locked=%0d hang=%0d: results=%0d sum=%0d error=%0d",
             w, r, locked, hang, rv_cnt, sum, error);
  endtask

  initial begin
    bit got;
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;

    // window=100 -> ~200 PLL cycles
    run_seq(32'd100, 8'd1, 1'b1, 1'b0, 1'b0);
    chk(result >= 198 && result <= 202, "pin_result_200", result, 200);
    chk(sum == 40'(result), "pin_sum_eq_result", sum, result);

    // three measurements, with a start pulse while busy that must be ignored
    run_seq(32'd50, 8'd3, 1'b1, 1'b0, 1'b1);
    chk(wlog.size() > 2 && wlog[1] == {4'd1, 32'd50}, "pin_count_num_50", wlog[1], 50);
    chk(rv_cnt == 3, "pin_three_results", rv_cnt, 3);

    // unlocked PLL
    run_seq(32'd20, 8'd2, 1'b0, 1'b0, 1'b0);

    // go never clears -> poll timeout
    run_seq(32'd30, 8'd1, 1'b1, 1'b1, 1'b0);
    chk(rv_cnt == 0, "pin_hang_no_result", rv_cnt, 0);

    // zero window / zero repeats are clamped to one
    run_seq(32'd0, 8'd0, 1'b1, 1'b0, 1'b0);
    chk(wlog.size() > 2 && wlog[1] == {4'd1, 32'd1}, "pin_count_num_1", wlog[1], 1);

    // reset during POLL_W, then a fresh sequence
    s_hang = 1'b0; s_locked = 1'b1;
    clear_model(60, 2);
    start = 1'b1; window = 32'd60; repeats = 8'd2;
    @(posedge clk); #1 start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(posedge clk); #1;
      if (bus.m_read && bus.m_address == 4'd0) got = 1'b1;
    end
    chk(got, "reach_poll", got, 1);
    @(posedge clk); #2 resetn = 1'b0;
    #1 chk_zero("abort");
    repeat (3) @(posedge clk);
    #1 chk_zero("abort_hold");
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
    run_seq(32'd40, 8'd2, 1'b1, 1'b0, 1'b0);

    // randomized sequences
    for (int n = 0; n < 8; n++) begin
      logic [31:0] w;
      logic [7:0]  r;
      w = ($urandom_range(7) == 0) ? 32'd0 : 32'($urandom_range(100, 1));
      r = 8'($urandom_range(4));
      run_seq(w, r, $urandom_range(5) != 0, $urandom_range(7) == 0, $urandom_range(1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
